lc3_core_hs: RTL and testbench
==============================

Name: lc3_core_hs

Overview:
Parametrised next-generation LC-3 multicycle core that replaces the fixed-latency memory interface with a req/ready handshake, so any number of memory wait states is tolerated.
- Adds a configurable reset PC and a HALT trap.
- Flags illegal opcodes.
- Fixes JMP/JSRR/AND/LEA semantics to the LC-3 ISA.
- Sits between the testbench memory model and the ISA reference checker; the memory model is single-port, one transaction at a time.

Parameters:
RESET_PC, 16'h0000, PC value loaded at reset.
HALT_EN, 1, 1 = TRAP with vector HALT_VECTOR enters HALTED state.
HALT_VECTOR, 8'h25, trap vector treated as halt.
NUM_WAIT_CHECK, 1, 1 = assert illegal if memory inputs change while memReq is low (sim-only check, no RTL effect).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
memReq  out  1  memory transaction request
writeEnable  out  1  1 = write, 0 = read; valid while memReq=1
address  out  16  transaction address; valid while memReq=1
dataToMemory  out  16  write data; valid while memReq=1 and writeEnable=1
dataFromMemory  in  16  read data; sampled in the cycle memReq&memReady
memReady  in  1  memory accepts/completes current transaction this cycle
halted  out  1  core stopped on HALT trap
illegal  out  1  one-cycle pulse on opcode 1000 (RTI) or 1101
pcOut  out  16  architectural PC (debug)

Behaviour:
- Reset (reset=0 at posedge) wins over everything, including a mid-transaction state.
  - State=FETCH; PC=RESET_PC; R0..R7=0; N=0, Z=1, P=0.
  - memReq=0, writeEnable=0, address=0, dataToMemory=0, halted=0, illegal=0.
  - Any pending transaction is abandoned; memReady during reset is ignored.
- Handshake:
  - memReq, address, writeEnable and dataToMemory are registered and held stable until the cycle where memReq=1 and memReady=1.
  - That cycle completes the transaction; read data is captured then.
  - memReq drops the next cycle (at least one idle cycle between transactions).
  - memReady while memReq=0 is ignored.
- States: FETCH, DECODE, EXEC, MEM, MEM2, WB, HALTED.
  - FETCH: memReq=1, address=PC, read. On completion: IR<=dataFromMemory, PC<=PC+1, go to DECODE.
  - DECODE: one cycle.
    - Opcodes 1000 and 1101: illegal=1 for one cycle, go to FETCH.
    - Other opcodes: go to EXEC.
  - EXEC:
    - ADD/AND/NOT: write DR, set NZP, go to FETCH.
    - LEA: DR<=PC+SEXT(off9), NZP unchanged.
    - BR: if (n&N)|(z&Z)|(p&P), PC<=PC+SEXT(off9). nzp=000 is a NOP.
    - JMP/RET: PC<=R[BaseR].
    - JSR (IR[11]=1): R7<=PC, PC<=PC+SEXT(off11).
    - JSRR: PC<=R[BaseR] read before the R7 update; R7<=PC. JSRR R7 therefore jumps to old R7.
    - LD/LDI/ST/STI: address = PC+SEXT(off9).
    - LDR/STR: address = R[BaseR]+SEXT(off6).
    - TRAP: R7<=PC, address = ZEXT(trapvect8).
    - Memory ops and TRAP then go to MEM.
  - MEM: issue the transaction.
    - Store data = R[IR[11:9]].
    - LD/LDR on completion: DR<=data, set NZP.
    - LDI/STI on completion: latch the pointer, go to MEM2.
    - TRAP on completion: PC<=data. If HALT_EN and trapvect8==HALT_VECTOR, go to HALTED, else FETCH.
  - MEM2: second transaction at the pointer address, then the same write-back as LD or ST.
  - HALTED: halted=1, memReq=0 forever; left only by reset.
- All arithmetic is mod 2^16; PC wraps FFFF->0000.
- NZP: N=r[15], Z=(r==0), P=!N&!Z. Exactly one flag is set after any flag write.
- Latency with memReady tied high:
  - ALU/BR/JMP/JSR/LEA: 3 cycles.
  - LD/ST/TRAP: 5 cycles.
  - LDI/STI: 7 cycles.
  - Each stall cycle adds 1.

Test Plan:
- Reset, then mem[0]=x1261 (ADD R1,R1,#1), memReady=1 -> FETCH at addr 0, R1=1, P=1, pcOut=1 after 3 cycles.
- Same program with memReady low 4 cycles per request -> address/memReq stable throughout the stall, R1=1 after 7 cycles, no duplicate fetch.
- R2=x0010, mem[x10]=x0020, mem[x20]=x8000, LDI R3 via pointer with random stalls -> R3=x8000, N=1; two data reads, to x10 then x20.
- R7=x0040, JSRR R7 (x41C0) -> PC=x0040 and R7=old PC+1, i.e. the address of the instruction following the JSRR.
- mem[x25]=x0300, TRAP x25 with HALT_EN=1 -> R7=PC, halted=1, memReq never reasserts. With HALT_EN=0 -> PC=x0300 and fetch continues.
- Assert reset mid-STI while memReq=1 with memReady=0 -> next cycle memReq=0, PC=RESET_PC, no write completes. Opcode xD000 -> illegal pulses for 1 cycle and state is unchanged.

Source files
------------

// File: rtl/lc3_core_hs.sv
// LC-3 multicycle core with a req/ready memory handshake, configurable reset PC,
// HALT trap and illegal-opcode pulse.
module lc3_core_hs #(
   parameter logic [15:0] RESET_PC       = 16'h0000,
   parameter bit          HALT_EN        = 1'b1,
   parameter logic [7:0]  HALT_VECTOR    = 8'h25,
   parameter bit          NUM_WAIT_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        memReq,
   output logic        writeEnable,
   output logic [15:0] address,
   output logic [15:0] dataToMemory,
   input  logic [15:0] dataFromMemory,
   input  logic        memReady,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] pcOut,
   output logic [2:0]  dbg_state
);

   // Handshake: memReq/address/writeEnable/dataToMemory are registered and held
   // until the cycle with memReq=1 and memReady=1, which completes the transfer
   // (read data captured then); memReq is low the following cycle.

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      MEM2   = 3'd4,
      WB     = 3'd5,
      HALTED = 3'd6
   } state_t;

   state_t      state, state_d;
   logic [15:0] pc, pc_d, ir, ir_d, addr_d, wdata_d;
   logic        req_d, we_d, ind, ind_d;
   logic [15:0] r [8];
   logic        flag_n, flag_z, flag_p;
   logic        rf_we, cc_we;
   logic [2:0]  rf_wa;
   logic [15:0] rf_wd;

   logic [3:0]  op;
   logic [2:0]  dr, sr1;
   logic [15:0] sext5, sext6, sext9, sext11, base, src2, alu;
   logic        done, illegal_op, halt_trap, br_taken, is_mem, is_store;

   assign op     = ir[15:12];
   assign dr     = ir[11:9];
   assign sr1    = ir[8:6];
   assign sext5  = {{11{ir[4]}}, ir[4:0]};
   assign sext6  = {{10{ir[5]}}, ir[5:0]};
   assign sext9  = {{7{ir[8]}}, ir[8:0]};
   assign sext11 = {{5{ir[10]}}, ir[10:0]};
   assign base   = r[sr1];
   assign src2   = ir[5] ? sext5 : r[ir[2:0]];
   assign done   = memReq & memReady;

   assign illegal_op = (op == OP_RTI) || (op == OP_RES);
   assign halt_trap  = HALT_EN && (ir[7:0] == HALT_VECTOR);
   assign br_taken   = (ir[11] & flag_n) | (ir[10] & flag_z) | (ir[9] & flag_p);
   assign is_mem     = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST) || (op == OP_STI) ||
                       (op == OP_LDR) || (op == OP_STR) || (op == OP_TRAP);
   assign is_store   = (op == OP_ST) || (op == OP_STR);

   assign halted    = (state == HALTED);
   assign illegal   = (state == DECODE) && illegal_op;
   assign pcOut     = pc;
   assign dbg_state = state;

   always_comb begin
      unique case (op)
         OP_ADD:  alu = base + src2;
         OP_AND:  alu = base & src2;
         default: alu = ~base;
      endcase
   end

   always_comb begin
      state_d = state;
      pc_d    = pc;
      ir_d    = ir;
      req_d   = memReq;
      we_d    = writeEnable;
      addr_d  = address;
      wdata_d = dataToMemory;
      ind_d   = ind;
      rf_we   = 1'b0;
      rf_wa   = dr;
      rf_wd   = '0;
      cc_we   = 1'b0;

      unique case (state)
         FETCH: begin
            if (!memReq) begin
               // Only reached straight after reset: every other path into
               // FETCH has already raised the request.
               req_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = pc;
            end else if (done) begin
               ir_d    = dataFromMemory;
               pc_d    = pc + 16'd1;
               req_d   = 1'b0;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (illegal_op) begin
               state_d = FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            unique case (op)
               OP_ADD, OP_AND, OP_NOT: begin
                  rf_we = 1'b1;
                  rf_wd = alu;
                  cc_we = 1'b1;
               end
               OP_LEA: begin
                  rf_we = 1'b1;
                  rf_wd = pc + sext9;
               end
               OP_BR:  if (br_taken) pc_d = pc + sext9;
               OP_JMP: pc_d = base;
               OP_JSR: begin
                  rf_we = 1'b1;
                  rf_wa = 3'd7;
                  rf_wd = pc;
                  pc_d  = ir[11] ? (pc + sext11) : base;
               end
               OP_LD, OP_LDI, OP_ST, OP_STI: addr_d = pc + sext9;
               OP_LDR, OP_STR:               addr_d = base + sext6;
               OP_TRAP: begin
                  rf_we  = 1'b1;
                  rf_wa  = 3'd7;
                  rf_wd  = pc;
                  addr_d = {8'h00, ir[7:0]};
               end
               default: ;
            endcase
            if (is_mem) begin
               state_d = MEM;
               req_d   = 1'b1;
               we_d    = is_store;
               wdata_d = r[dr];
            end else begin
               state_d = FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_d;
            end
         end
         MEM: begin
            if (done) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = WB;
               if ((op == OP_LD) || (op == OP_LDR)) begin
                  rf_we = 1'b1;
                  rf_wd = dataFromMemory;
                  cc_we = 1'b1;
               end else if ((op == OP_LDI) || (op == OP_STI)) begin
                  // Pointer parks in the address register until WB reissues it.
                  ind_d  = 1'b1;
                  addr_d = dataFromMemory;
               end else if (op == OP_TRAP) begin
                  pc_d = dataFromMemory;
                  if (halt_trap) state_d = HALTED;
               end
            end
         end
         MEM2: begin
            if (done) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = WB;
               if (op == OP_LDI) begin
                  rf_we = 1'b1;
                  rf_wd = dataFromMemory;
                  cc_we = 1'b1;
               end
            end
         end
         WB: begin
            // WB is the mandatory idle cycle between two transactions.
            req_d = 1'b1;
            if (ind) begin
               ind_d   = 1'b0;
               we_d    = (op == OP_STI);
               wdata_d = r[dr];
               state_d = MEM2;
            end else begin
               we_d    = 1'b0;
               addr_d  = pc;
               state_d = FETCH;
            end
         end
         HALTED: req_d = 1'b0;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         ir           <= '0;
         memReq       <= 1'b0;
         writeEnable  <= 1'b0;
         address      <= '0;
         dataToMemory <= '0;
         ind          <= 1'b0;
         flag_n       <= 1'b0;
         flag_z       <= 1'b1;
         flag_p       <= 1'b0;
         for (int i = 0; i < 8; i++) r[i] <= '0;
      end else begin
         state        <= state_d;
         pc           <= pc_d;
         ir           <= ir_d;
         memReq       <= req_d;
         writeEnable  <= we_d;
         address      <= addr_d;
         dataToMemory <= wdata_d;
         ind          <= ind_d;
         if (rf_we) r[rf_wa] <= rf_wd;
         if (cc_we) begin
            flag_n <= rf_wd[15];
            flag_z <= (rf_wd == 16'h0000);
            flag_p <= !rf_wd[15] && (rf_wd != 16'h0000);
         end
      end
   end

   // Memory side must hold its inputs steady while no request is outstanding.
   if (NUM_WAIT_CHECK) begin : g_wait_check
      property p_idle_inputs_stable;
         @(posedge clk) disable iff (!reset)
            (!memReq && $past(!memReq) && $past(reset)) |-> ($stable(memReady) && $stable(dataFromMemory));
      endproperty
      assert property (p_idle_inputs_stable);
   end

endmodule

// File: tb/tb_lc3_core_hs.sv
// Directed bench for lc3_core_hs: handshake memory model with selectable stalls
// and per-scenario tasks that compare against hand-computed values.
module tb_lc3_core_hs;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memReq, writeEnable, halted, illegal;
   logic [15:0] address, dataToMemory, pcOut;
   logic [15:0] dataFromMemory = 16'h0000;
   logic        memReady = 1'b0;
   logic [2:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   lc3_core_hs #(
      .RESET_PC(16'h0000), .HALT_EN(1'b1), .HALT_VECTOR(8'h25), .NUM_WAIT_CHECK(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .memReq(memReq), .writeEnable(writeEnable),
      .address(address), .dataToMemory(dataToMemory), .dataFromMemory(dataFromMemory),
      .memReady(memReady), .halted(halted), .illegal(illegal), .pcOut(pcOut),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // memory model: 0 = no stall, 1 = fixed stall, 2 = random stall, 3 = writes never ready
   logic [15:0] mem [0:65535];
   logic [15:0] rd_log[$];
   logic [15:0] wr_addr[$];
   logic [15:0] wr_data[$];
   int          mem_mode = 0;
   int          stall_fixed = 0;
   int          stall_left = 0;
   bit          in_txn = 1'b0;

   always @(negedge clk) begin
      if (memReq === 1'b1) begin
         if (!in_txn) begin
            in_txn = 1'b1;
            case (mem_mode)
               1:       stall_left = stall_fixed;
               2:       stall_left = $urandom_range(0, 3);
               default: stall_left = 0;
            endcase
         end
         if (mem_mode == 3 && writeEnable === 1'b1) begin
            memReady = 1'b0;
         end else begin
            memReady = (stall_left == 0);
            if (stall_left > 0) stall_left--;
         end
         dataFromMemory = mem[address];
      end else begin
         in_txn = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (reset === 1'b1 && memReq === 1'b1 && memReady === 1'b1) begin
         if (writeEnable === 1'b1) begin
            mem[address] = dataToMemory;
            wr_addr.push_back(address);
            wr_data.push_back(dataToMemory);
         end else begin
            rd_log.push_back(address);
         end
         in_txn = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_test(input int mode);
      @(negedge clk);
      reset = 1'b0;
      mem_mode = mode;
      rd_log.delete();
      wr_addr.delete();
      wr_data.delete();
      for (int i = 0; i < 16'h0600; i++) mem[i] = 16'h0000;
      repeat (2) @(posedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_req(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (memReq === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_halt(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (halted === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      begin_test(0);
      #1;
      total++; if (memReq !== 1'b0) begin bad++; $display("FAIL reset_memreq got=%b want=0", memReq); end
      total++; if (writeEnable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", writeEnable); end
      total++; if (address !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", address); end
      total++; if (dataToMemory !== 16'h0000) begin bad++; $display("FAIL reset_wdata got=%h want=0000", dataToMemory); end
      total++; if (halted !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL reset_flags_out got=%b%b want=00", halted, illegal); end
      total++; if (pcOut !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", pcOut); end
      total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
      total++;
      if ({dut.flag_n, dut.flag_z, dut.flag_p} !== 3'b010 || dut.r[7] !== 16'h0000) begin
         bad++; $display("FAIL reset_nzp_r7 got=%b/%h want=010/0000", {dut.flag_n, dut.flag_z, dut.flag_p}, dut.r[7]);
      end
      release_reset();
      wait_req(5, ok);
      total++; if (!ok || address !== 16'h0000 || writeEnable !== 1'b0) begin
         bad++; $display("FAIL reset_first_fetch ok=%b addr=%h we=%b want addr=0000 we=0", ok, address, writeEnable);
      end
   endtask

   task automatic test_add_halt();
      bit ok;
      int req_seen;
      begin_test(0);
      mem[16'h0000] = 16'h1261;
      mem[16'h0001] = 16'hF025;
      mem[16'h0025] = 16'h0300;
      release_reset();
      wait_req(5, ok);
      total++; if (!ok || address !== 16'h0000) begin bad++; $display("FAIL add_fetch_addr ok=%b got=%h want=0000", ok, address); end
      tick(); tick();
      total++; if (dut.r[1] !== 16'h0000) begin bad++; $display("FAIL add_early got=%h want=0000", dut.r[1]); end
      tick();
      total++; if (dut.r[1] !== 16'h0001) begin bad++; $display("FAIL add_r1 got=%h want=0001", dut.r[1]); end
      total++; if ({dut.flag_n, dut.flag_z, dut.flag_p} !== 3'b001) begin bad++; $display("FAIL add_nzp got=%b want=001", {dut.flag_n, dut.flag_z, dut.flag_p}); end
      total++; if (pcOut !== 16'h0001 || dbg_state !== 3'd0) begin bad++; $display("FAIL add_pc got=%h/%0d want=0001/0", pcOut, dbg_state); end
      tick(); tick(); tick();
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b want=0", halted); end
      tick();
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_latency got=%b want=1", halted); end
      total++; if (dut.r[7] !== 16'h0002 || pcOut !== 16'h0300) begin bad++; $display("FAIL halt_r7_pc got=%h/%h want=0002/0300", dut.r[7], pcOut); end
      req_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (memReq !== 1'b0 || halted !== 1'b1) req_seen++;
      end
      total++; if (req_seen != 0) begin bad++; $display("FAIL halt_stays got=%0d want=0", req_seen); end
   endtask

   task automatic test_stall();
      bit ok;
      int unstable;
      begin_test(1);
      stall_fixed = 4;
      mem[16'h0000] = 16'h1261;
      mem[16'h0001] = 16'hF025;
      mem[16'h0025] = 16'h0300;
      release_reset();
      wait_req(5, ok);
      unstable = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (memReq !== 1'b1 || address !== 16'h0000 || writeEnable !== 1'b0) unstable++;
      end
      total++; if (!ok || unstable != 0) begin bad++; $display("FAIL stall_hold ok=%b got=%0d want=0", ok, unstable); end
      tick(); tick();
      total++; if (dut.r[1] !== 16'h0000) begin bad++; $display("FAIL stall_early got=%h want=0000", dut.r[1]); end
      tick();
      total++; if (dut.r[1] !== 16'h0001) begin bad++; $display("FAIL stall_r1 got=%h want=0001", dut.r[1]); end
      wait_halt(60, ok);
      total++;
      if (!ok || rd_log.size() != 3 || rd_log[0] !== 16'h0000 || rd_log[1] !== 16'h0001 || rd_log[2] !== 16'h0025) begin
         bad++; $display("FAIL stall_reads ok=%b got_n=%0d want=3 reads 0000,0001,0025", ok, rd_log.size());
      end
   endtask

   task automatic test_ldi();
      bit ok;
      logic [15:0] exp_rd [9];
      int n_bad;
      begin_test(2);
      mem[16'h0000] = 16'h240E;
      mem[16'h0001] = 16'h6880;
      mem[16'h0002] = 16'hA60D;
      mem[16'h0003] = 16'hF025;
      mem[16'h000F] = 16'h0010;
      mem[16'h0010] = 16'h0020;
      mem[16'h0020] = 16'h8000;
      mem[16'h0025] = 16'h0300;
      exp_rd = '{16'h0000, 16'h000F, 16'h0001, 16'h0010, 16'h0002, 16'h0010, 16'h0020, 16'h0003, 16'h0025};
      release_reset();
      wait_halt(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL ldi_halt got=0 want=1"); end
      total++; if (dut.r[2] !== 16'h0010 || dut.r[4] !== 16'h0020) begin bad++; $display("FAIL ldi_r2_r4 got=%h/%h want=0010/0020", dut.r[2], dut.r[4]); end
      total++; if (dut.r[3] !== 16'h8000) begin bad++; $display("FAIL ldi_r3 got=%h want=8000", dut.r[3]); end
      total++; if ({dut.flag_n, dut.flag_z, dut.flag_p} !== 3'b100) begin bad++; $display("FAIL ldi_nzp got=%b want=100", {dut.flag_n, dut.flag_z, dut.flag_p}); end
      n_bad = 0;
      if (rd_log.size() != 9) n_bad = 99;
      else for (int i = 0; i < 9; i++) if (rd_log[i] !== exp_rd[i]) n_bad++;
      total++; if (n_bad != 0 || wr_addr.size() != 0) begin bad++; $display("FAIL ldi_reads got_n=%0d wrong=%0d writes=%0d want 9/0/0", rd_log.size(), n_bad, wr_addr.size()); end
   endtask

   task automatic test_jsrr_trap();
      bit ok, seen40, seen300;
      begin_test(0);
      mem[16'h0000] = 16'h2E0E;
      mem[16'h0001] = 16'h41C0;
      mem[16'h000F] = 16'h0040;
      mem[16'h0040] = 16'hF026;
      mem[16'h0026] = 16'h0300;
      mem[16'h0300] = 16'hF025;
      mem[16'h0025] = 16'h0500;
      release_reset();
      seen40 = 1'b0;
      seen300 = 1'b0;
      for (int i = 0; i < 100 && !seen300; i++) begin
         tick();
         if (!seen40 && pcOut === 16'h0040 && dbg_state === 3'd0) begin
            seen40 = 1'b1;
            total++; if (dut.r[7] !== 16'h0002) begin bad++; $display("FAIL jsrr_r7 got=%h want=0002", dut.r[7]); end
         end
         if (pcOut === 16'h0300 && dbg_state === 3'd0) begin
            seen300 = 1'b1;
            total++; if (dut.r[7] !== 16'h0041 || halted !== 1'b0) begin bad++; $display("FAIL trap_nohalt r7=%h halted=%b want=0041/0", dut.r[7], halted); end
         end
      end
      total++; if (!seen40 || !seen300) begin bad++; $display("FAIL jsrr_path got=%b%b want=11", seen40, seen300); end
      wait_halt(50, ok);
      total++; if (!ok || pcOut !== 16'h0500 || dut.r[7] !== 16'h0301) begin bad++; $display("FAIL trap_halt ok=%b pc=%h r7=%h want 0500/0301", ok, pcOut, dut.r[7]); end
   endtask

   task automatic test_alu_branch();
      bit ok;
      begin_test(0);
      mem[0] = 16'h5020;  mem[1] = 16'h0401;  mem[2] = 16'h1027;  mem[3] = 16'h923F;
      mem[4] = 16'hEA0A;  mem[5] = 16'h0801;  mem[6] = 16'h1027;  mem[7] = 16'h3208;
      mem[8] = 16'h7A42;  mem[9] = 16'h0005;  mem[10] = 16'h1441; mem[11] = 16'hF025;
      mem[16'h0025] = 16'h0300;
      release_reset();
      wait_halt(200, ok);
      total++; if (!ok || dut.r[0] !== 16'h0000) begin bad++; $display("FAIL br_skip ok=%b r0=%h want=0000", ok, dut.r[0]); end
      total++; if (dut.r[1] !== 16'hFFFF || dut.r[2] !== 16'hFFFE) begin bad++; $display("FAIL not_add got=%h/%h want=FFFF/FFFE", dut.r[1], dut.r[2]); end
      total++; if (dut.r[5] !== 16'h000F) begin bad++; $display("FAIL lea got=%h want=000F", dut.r[5]); end
      total++; if (dut.r[7] !== 16'h000C || {dut.flag_n, dut.flag_z, dut.flag_p} !== 3'b100) begin bad++; $display("FAIL alu_r7_nzp got=%h/%b want=000C/100", dut.r[7], {dut.flag_n, dut.flag_z, dut.flag_p}); end
      total++;
      if (wr_addr.size() != 2 || wr_addr[0] !== 16'h0010 || wr_data[0] !== 16'hFFFF || wr_addr[1] !== 16'h0001 || wr_data[1] !== 16'h000F) begin
         bad++; $display("FAIL st_str got_n=%0d want 2 writes 0010=FFFF 0001=000F", wr_addr.size());
      end
   endtask

   task automatic test_reset_mid_sti();
      bit ok;
      begin_test(3);
      mem[16'h0000] = 16'hB20E;
      mem[16'h000F] = 16'h0030;
      mem[16'h0030] = 16'hBEEF;
      release_reset();
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (memReq === 1'b1 && writeEnable === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      total++; if (!ok || address !== 16'h0030 || dataToMemory !== 16'h0000) begin bad++; $display("FAIL sti_write ok=%b addr=%h data=%h want 0030/0000", ok, address, dataToMemory); end
      tick();
      total++; if (memReq !== 1'b1 || address !== 16'h0030) begin bad++; $display("FAIL sti_hold got=%b/%h want=1/0030", memReq, address); end
      reset = 1'b0;
      tick();
      total++; if (memReq !== 1'b0 || writeEnable !== 1'b0 || address !== 16'h0000) begin bad++; $display("FAIL midreset_bus got=%b%b/%h want=00/0000", memReq, writeEnable, address); end
      total++; if (pcOut !== 16'h0000 || dbg_state !== 3'd0) begin bad++; $display("FAIL midreset_pc got=%h/%0d want=0000/0", pcOut, dbg_state); end
      total++; if (mem[16'h0030] !== 16'hBEEF || wr_addr.size() != 0) begin bad++; $display("FAIL midreset_nowrite got=%h/%0d want=BEEF/0", mem[16'h0030], wr_addr.size()); end
      release_reset();
      wait_req(5, ok);
      total++; if (!ok || address !== 16'h0000) begin bad++; $display("FAIL midreset_refetch ok=%b addr=%h want=0000", ok, address); end
   endtask

   task automatic test_illegal();
      bit ok, prev;
      int pulses, back_to_back;
      begin_test(0);
      mem[0] = 16'h1265;
      mem[1] = 16'hD000;
      mem[2] = 16'h8000;
      mem[3] = 16'hF025;
      mem[16'h0025] = 16'h0300;
      release_reset();
      pulses = 0;
      back_to_back = 0;
      prev = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (illegal === 1'b1) begin
            if (prev) back_to_back++;
            if (pulses == 0) begin
               total++; if (pcOut !== 16'h0002 || dut.r[1] !== 16'h0005) begin bad++; $display("FAIL illegal_first pc=%h r1=%h want 0002/0005", pcOut, dut.r[1]); end
            end
            pulses++;
         end
         prev = (illegal === 1'b1);
         if (halted === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      total++; if (pulses != 2 || back_to_back != 0) begin bad++; $display("FAIL illegal_pulses got=%0d/%0d want=2/0", pulses, back_to_back); end
      total++; if (!ok || dut.r[1] !== 16'h0005 || dut.r[7] !== 16'h0004) begin bad++; $display("FAIL illegal_state ok=%b r1=%h r7=%h want 0005/0004", ok, dut.r[1], dut.r[7]); end
      total++; if ({dut.flag_n, dut.flag_z, dut.flag_p} !== 3'b001) begin bad++; $display("FAIL illegal_nzp got=%b want=001", {dut.flag_n, dut.flag_z, dut.flag_p}); end
   endtask

   initial begin
      test_reset();
      test_add_halt();
      test_stall();
      test_ldi();
      test_jsrr_trap();
      test_alu_branch();
      test_reset_mid_sti();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
